m_ext_issue_controller: RTL and testbench

Pipeline-side initiator for `execution_unit_multi_cycle`. It accepts one M-extension operation from decode and launches it into the execution unit with stable operands. It then waits for the unit's result strobe and returns the result to writeback as a single-cycle pulse. While an operation is in flight it stalls the upstream pipeline, and it also handles flush, timeout and busy-cycle accounting.

---
 rtl/m_ext_issue_controller.sv | 185 ++++++++++++++++++
 tb/tb_m_ext_issue_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_issue_controller.sv
// m_ext_issue_controller
// Launches one M-extension operation into the multi-cycle execution unit,
// waits for its result strobe and hands the result to writeback as a
// one-cycle pulse. Handles flush, a launch/wait watchdog and busy accounting.
module m_ext_issue_controller #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [5:0]            issue_ALU_operation,
    input  logic [DATA_WIDTH-1:0] issue_rs1_data,
    input  logic [DATA_WIDTH-1:0] issue_rs2_data,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_flush,
    output logic [5:0]            ex_ALU_operation,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic                  ex_ready_i,
    input  logic                  ex_ready_o,
    input  logic                  ex_valid_result,
    input  logic [DATA_WIDTH-1:0] ex_ALU_result,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic                  stall,
    output logic                  illegal_op,
    output logic                  timeout,
    output logic [15:0]           busy_cycles,
    input  logic                  scan
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [5:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0]   rs2_q, rs2_d;
    logic [4:0]              rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             busy_q, busy_d;
    logic [WD_W-1:0]         wd_q, wd_d;

    logic is_m_op;
    logic accept;
    logic in_flight;
    logic wd_expired;

    // Debug printing of writebacks is done outside synthesizable logic;
    // scan and CORE carry no function here.
    logic unused_dbg;
    assign unused_dbg = scan | (CORE != 0);

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state, operand latching, watchdog and busy accounting
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        wd_d      = wd_q;

        is_m_op    = (issue_ALU_operation >= 6'd20) && (issue_ALU_operation <= 6'd27);
        accept     = (state_q == S_IDLE) && issue_valid && !issue_flush;
        in_flight  = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        wd_expired = in_flight && (wd_q == WD_LAST);
        illegal_d  = accept && !is_m_op;

        if (in_flight) begin
            wd_d = wd_q + 1'b1;
        end

        if ((in_flight || (state_q == S_DRAIN)) && (busy_q != '1)) begin
            busy_d = busy_q + 16'd1;
        end

        // Flush outranks the watchdog, which outranks normal progress
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_m_op) begin
                    state_d = S_LAUNCH;
                    op_d    = issue_ALU_operation;
                    rs1_d   = issue_rs1_data;
                    rs2_d   = issue_rs2_data;
                    rd_d    = issue_rd;
                    wd_d    = '0;
                end
            end
            S_LAUNCH: begin
                if (issue_flush) begin
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else if (ex_ready_o) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (issue_flush) begin
                    state_d = S_DRAIN;
                end else if (wd_expired) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else if (ex_valid_result) begin
                    state_d  = S_DONE;
                    result_d = ex_ALU_result;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (ex_valid_result) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        issue_ready = (state_q == S_IDLE) && !issue_flush;
        ex_ready_i  = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_DRAIN);
        wb_valid    = (state_q == S_DONE) && !issue_flush;
        stall       = (state_q != S_IDLE);
    end

    assign ex_ALU_operation = op_q;
    assign ex_rs1_data      = rs1_q;
    assign ex_rs2_data      = rs2_q;
    assign wb_rd            = rd_q;
    assign wb_result        = result_q;
    assign illegal_op       = illegal_q;
    assign timeout          = timeout_q;
    assign busy_cycles      = busy_q;

endmodule

// File: tb/tb_m_ext_issue_controller.sv
// tb_m_ext_issue_controller
// Directed stimulus with a per-cycle comparison against a transaction-level
// model of the controller, plus literal expectations for each scenario.
module tb_m_ext_issue_controller;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clock;
    logic          reset;
    logic          issue_valid;
    logic          issue_ready;
    logic [5:0]    issue_ALU_operation;
    logic [DW-1:0] issue_rs1_data;
    logic [DW-1:0] issue_rs2_data;
    logic [4:0]    issue_rd;
    logic          issue_flush;
    logic [5:0]    ex_ALU_operation;
    logic [DW-1:0] ex_rs1_data;
    logic [DW-1:0] ex_rs2_data;
    logic          ex_ready_i;
    logic          ex_ready_o;
    logic          ex_valid_result;
    logic [DW-1:0] ex_ALU_result;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_result;
    logic          stall;
    logic          illegal_op;
    logic          timeout;
    logic [15:0]   busy_cycles;
    logic          scan;

    m_ext_issue_controller #(
        .CORE(0),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_ALU_operation(issue_ALU_operation),
        .issue_rs1_data(issue_rs1_data),
        .issue_rs2_data(issue_rs2_data),
        .issue_rd(issue_rd),
        .issue_flush(issue_flush),
        .ex_ALU_operation(ex_ALU_operation),
        .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data),
        .ex_ready_i(ex_ready_i),
        .ex_ready_o(ex_ready_o),
        .ex_valid_result(ex_valid_result),
        .ex_ALU_result(ex_ALU_result),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_result(wb_result),
        .stall(stall),
        .illegal_op(illegal_op),
        .timeout(timeout),
        .busy_cycles(busy_cycles),
        .scan(scan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // pending: an op is owned by the controller and not yet resolved
    // started: the unit has taken the op
    // dropping: a flushed op whose result must still be swallowed
    // have: a result is being handed to writeback this cycle
    bit          m_pending, m_started, m_dropping, m_have;
    bit          m_illegal, m_timeout;
    int          m_wd, m_busy;
    logic [5:0]  m_op;
    logic [31:0] m_rs1, m_rs2, m_res;
    logic [4:0]  m_rd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pending  <= 0; m_started <= 0; m_dropping <= 0; m_have <= 0;
            m_illegal  <= 0; m_timeout <= 0; m_wd <= 0; m_busy <= 0;
            m_op <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_res <= '0;
        end else begin
            automatic bit idle = !m_pending && !m_dropping && !m_have;
            automatic bit acc  = idle && issue_valid && !issue_flush;
            automatic bit mop  = (issue_ALU_operation >= 6'd20) && (issue_ALU_operation <= 6'd27);
            m_illegal <= acc && !mop;
            if (m_pending || m_dropping)
                m_busy <= (m_busy < 65535) ? m_busy + 1 : m_busy;
            if (acc && mop) begin
                m_pending <= 1; m_started <= 0; m_wd <= 0;
                m_op <= issue_ALU_operation; m_rs1 <= issue_rs1_data;
                m_rs2 <= issue_rs2_data; m_rd <= issue_rd;
            end else if (m_pending) begin
                m_wd <= m_wd + 1;
                if (issue_flush) begin
                    m_pending <= 0; m_dropping <= m_started;
                end else if (m_wd + 1 >= TO) begin
                    m_pending <= 0; m_timeout <= 1;
                end else if (!m_started) begin
                    if (ex_ready_o) m_started <= 1;
                end else if (ex_valid_result) begin
                    m_res <= ex_ALU_result; m_have <= 1; m_pending <= 0;
                end
            end else if (m_dropping) begin
                if (ex_valid_result) m_dropping <= 0;
            end else if (m_have) begin
                m_have <= 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (run && !reset) begin
            automatic bit idle = !m_pending && !m_dropping && !m_have;
            chk("issue_ready", issue_ready, idle && !issue_flush);
            chk("ex_ready_i", ex_ready_i, m_pending || m_dropping);
            chk("stall", stall, !idle);
            chk("wb_valid", wb_valid, m_have && !issue_flush);
            chk("illegal_op", illegal_op, m_illegal);
            chk("timeout", timeout, m_timeout);
            chk("busy_cycles", busy_cycles, m_busy);
            chk("ex_op", ex_ALU_operation, m_op);
            chk("ex_rs1", ex_rs1_data, m_rs1);
            chk("ex_rs2", ex_rs2_data, m_rs2);
            if (m_have && !issue_flush) begin
                chk("wb_rd", wb_rd, m_rd);
                chk("wb_result", wb_result, m_res);
            end
        end
    end

    // Event counters for literal per-scenario expectations
    int          stall_cnt, wb_cnt;
    logic [31:0] last_res;
    logic [4:0]  last_rd;
    always @(negedge clock) begin
        if (!reset) begin
            if (stall) stall_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                last_res = wb_result;
                last_rd  = wb_rd;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        issue_valid         = 1'b1;
        issue_ALU_operation = op;
        issue_rs1_data      = a;
        issue_rs2_data      = b;
        issue_rd            = rd;
    endtask

    task automatic clr_cnt();
        stall_cnt = 0;
        wb_cnt    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; issue_valid = 0; issue_ALU_operation = '0; issue_rs1_data = '0;
        issue_rs2_data = '0; issue_rd = '0; issue_flush = 0; ex_ready_o = 0;
        ex_valid_result = 0; ex_ALU_result = '0; scan = 1'b1;
        stall_cnt = 0; wb_cnt = 0; last_res = '0; last_rd = '0;
        step(); step();

        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_ex_ready_i", ex_ready_i, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ex_op", ex_ALU_operation, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_busy", busy_cycles, 0);
        reset = 1'b0;
        run   = 1'b1;
        step();

        // MUL 4x7, result two cycles after launch
        clr_cnt(); ex_ready_o = 1;
        issue(6'd20, 32'd4, 32'd7, 5'd5);
        step(); issue_valid = 0;
        chk("t1_launch_ex_ready_i", ex_ready_i, 1);
        chk("t1_launch_rs1", ex_rs1_data, 4);
        step(); step();
        ex_valid_result = 1; ex_ALU_result = 32'd28;
        step(); ex_valid_result = 0; ex_ALU_result = '0;
        step(); step();
        chk("t1_stall_cycles", stall_cnt, 4);
        chk("t1_wb_count", wb_cnt, 1);
        chk("t1_wb_result", last_res, 28);
        chk("t1_wb_rd", last_rd, 5);
        chk("t1_busy", busy_cycles, 3);

        // Handshake held off for three LAUNCH cycles
        clr_cnt(); ex_ready_o = 0;
        issue(6'd21, 32'h1234, 32'h55, 5'd9);
        step(); issue_valid = 0;
        step(); step();
        chk("t2_held_rs1", ex_rs1_data, 32'h1234);
        chk("t2_held_rs2", ex_rs2_data, 32'h55);
        step(); ex_ready_o = 1;
        step(); ex_valid_result = 1; ex_ALU_result = 32'h600;
        step(); ex_valid_result = 0;
        step(); step();
        chk("t2_stall_cycles", stall_cnt, 6);
        chk("t2_wb_result", last_res, 32'h600);
        chk("t2_busy", busy_cycles, 8);

        // Flush in WAIT drains the later result
        clr_cnt();
        issue(6'd22, 32'd3, 32'd3, 5'd3);
        step(); issue_valid = 0;
        step(); issue_flush = 1;
        step(); issue_flush = 0;
        chk("t3_drain_ex_ready_i", ex_ready_i, 1);
        step(); ex_valid_result = 1; ex_ALU_result = 32'hDEAD;
        step(); ex_valid_result = 0;
        step(); step();
        chk("t3_wb_count", wb_cnt, 0);
        chk("t3_stall_cycles", stall_cnt, 4);
        chk("t3_busy", busy_cycles, 12);
        issue_flush = 1; #1;
        chk("t3_idle_flush_ready", issue_ready, 0);
        issue_flush = 0;
        step();

        // Non-M op
        clr_cnt();
        issue(6'd12, 32'd1, 32'd1, 5'd7);
        step(); issue_valid = 0;
        chk("t4_illegal_pulse", illegal_op, 1);
        chk("t4_ex_ready_i", ex_ready_i, 0);
        chk("t4_stall", stall, 0);
        step();
        chk("t4_illegal_clear", illegal_op, 0);
        chk("t4_stall_cycles", stall_cnt, 0);

        // Flush in LAUNCH
        issue(6'd27, 32'd8, 32'd9, 5'd10);
        step(); issue_valid = 0; issue_flush = 1;
        step(); issue_flush = 0;
        chk("t5_stall", stall, 0);
        chk("t5_busy", busy_cycles, 13);
        step();

        // Minimum latency, then back-to-back op issued during DONE
        clr_cnt();
        issue(6'd20, 32'd2, 32'd3, 5'd1);
        step(); issue_valid = 0;
        step(); ex_valid_result = 1; ex_ALU_result = 32'd6;
        step(); ex_valid_result = 0;
        chk("t6_min_latency_wb", wb_valid, 1);
        chk("t6_result", wb_result, 6);
        issue(6'd21, 32'd5, 32'd5, 5'd4);
        step();
        step(); issue_valid = 0;
        step(); ex_valid_result = 1; ex_ALU_result = 32'd25;
        step(); ex_valid_result = 0;
        step(); step();
        chk("t6_wb_count", wb_cnt, 2);
        chk("t6_last_rd", last_rd, 4);
        chk("t6_busy", busy_cycles, 17);

        // Flush during DONE suppresses writeback
        clr_cnt();
        issue(6'd24, 32'd6, 32'd6, 5'd2);
        step(); issue_valid = 0;
        step(); ex_valid_result = 1; ex_ALU_result = 32'd36;
        step(); ex_valid_result = 0; issue_flush = 1; #1;
        chk("t7_wb_suppressed", wb_valid, 0);
        step(); issue_flush = 0;
        step();
        chk("t7_wb_count", wb_cnt, 0);
        chk("t7_stall_cycles", stall_cnt, 3);
        chk("t7_busy", busy_cycles, 19);

        // Watchdog: no result ever arrives
        clr_cnt();
        issue(6'd23, 32'd9, 32'd9, 5'd8);
        step(); issue_valid = 0;
        repeat (11) step();
        chk("t8_timeout", timeout, 1);
        chk("t8_stall_cycles", stall_cnt, TO);
        chk("t8_wb_count", wb_cnt, 0);
        chk("t8_busy", busy_cycles, 27);
        step();
        chk("t8_timeout_sticky", timeout, 1);

        // Asynchronous reset while in WAIT
        issue(6'd26, 32'd1, 32'd2, 5'd6);
        step(); issue_valid = 0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("t9_stall", stall, 0);
        chk("t9_ex_ready_i", ex_ready_i, 0);
        chk("t9_issue_ready", issue_ready, 1);
        chk("t9_ex_rs1", ex_rs1_data, 0);
        chk("t9_wb_rd", wb_rd, 0);
        chk("t9_timeout", timeout, 0);
        chk("t9_busy", busy_cycles, 0);
        step();
        reset = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
